// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the capture controller.
//   state_e    - controller state encoding
//   DROP_CNT_W - width of the dropped-sample counter
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        DONE    = 3'd3,
        READOUT = 3'd4
    } state_e;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: sample input strobe and readout stream of the capture
// controller.
//   din_valid/din          - producer -> controller sample input
//   dout/dout_valid        - controller -> consumer readout word
//   dout_ready             - consumer accepts dout
// Modports: master = sample producer / readout consumer, slave = controller.
interface capture_ctrl_if #(
    parameter int DWIDTH = 8
);
    logic              din_valid;
    logic [DWIDTH-1:0] din;
    logic [DWIDTH-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output din_valid, din, dout_ready,
        input  dout, dout_valid
    );

    modport slave (
        input  din_valid, din, dout_ready,
        output dout, dout_valid
    );
endinterface

// File: rtl/capture_ctrl_sample_ram.sv
// sample_ram: single-port MAX_DATA x DWIDTH buffer, synchronous write and
// registered read. No reset on storage or read register.
//   clk_i   - clock
//   we_i    - write enable (wdata_i -> mem[addr_i])
//   re_i    - read enable (mem[addr_i] -> rdata_o next cycle, held otherwise)
//   addr_i  - shared address
//   wdata_i - write data
//   rdata_o - registered read data
module sample_ram #(
    parameter int MAX_DATA = 256,
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = $clog2(MAX_DATA)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    output logic [DWIDTH-1:0] rdata_o
);
    logic [DWIDTH-1:0] mem [MAX_DATA];
    logic [DWIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: triggered sample capture into a MAX_DATA-word buffer,
// followed by an in-order valid/ready readout.
//   clk, rst  - clock, synchronous active-high reset
//   start     - arm from IDLE
//   trig      - start capture while ARMED (level)
//   abort     - return to IDLE from any state (highest priority)
//   rd_start  - start readout from DONE
//   bus       - capture_ctrl_if.slave: din_valid/din in, dout/dout_valid out,
//               dout_ready in
//   busy      - ARMED, CAPTURE or READOUT
//   done      - DONE
//   wr_addr   - buffer fill level
//   drop_cnt  - saturating count of samples offered while not capturing
// Build option: CAPTURE_CTRL_DROP_CNT_EN enables the drop counter; without it
// drop_cnt is tied to zero.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int MAX_DATA = 256,
    parameter int DWIDTH   = 8,
    localparam int AWIDTH  = $clog2(MAX_DATA)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  trig,
    input  logic                  abort,
    input  logic                  rd_start,
    capture_ctrl_if.slave         bus,
    output logic                  busy,
    output logic                  done,
    output logic [AWIDTH-1:0]     wr_addr,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MAX_DATA - 1);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [AWIDTH-1:0] rd_addr_q, rd_addr_d;
    logic              rd_all_q, rd_all_d;   // every word has been read from RAM
    logic              dout_valid_q, dout_valid_d;
    logic              we, re;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            rd_all_q     <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            rd_all_q     <= rd_all_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        rd_all_d     = rd_all_q;
        dout_valid_d = dout_valid_q;
        we           = 1'b0;
        re           = 1'b0;
        if (abort) begin
            state_d      = IDLE;
            wr_addr_d    = '0;
            rd_addr_d    = '0;
            rd_all_d     = 1'b0;
            dout_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE:  if (start) state_d = ARMED;
                ARMED: begin
                    if (trig) begin
                        state_d = CAPTURE;
                        we      = bus.din_valid;
                    end
                end
                CAPTURE: we = bus.din_valid;
                DONE: begin
                    if (rd_start) begin
                        state_d   = READOUT;
                        rd_addr_d = '0;
                        rd_all_d  = 1'b0;
                    end
                end
                READOUT: begin
                    // Once all reads are issued, the only word left is the one
                    // on dout; its transfer ends the readout.
                    if (dout_valid_q && bus.dout_ready && rd_all_q) begin
                        state_d      = IDLE;
                        dout_valid_d = 1'b0;
                        rd_all_d     = 1'b0;
                    end else if (!dout_valid_q || bus.dout_ready) begin
                        dout_valid_d = !rd_all_q;
                        if (!rd_all_q) begin
                            re = 1'b1;
                            if (rd_addr_q == LAST_ADDR) begin
                                rd_addr_d = '0;
                                rd_all_d  = 1'b1;
                            end else begin
                                rd_addr_d = rd_addr_q + AWIDTH'(1);
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (we) begin
                if (wr_addr_q == LAST_ADDR) begin
                    wr_addr_d = '0;
                    state_d   = DONE;
                end else begin
                    wr_addr_d = wr_addr_q + AWIDTH'(1);
                end
            end
        end
    end

    assign ram_addr = (state_q == READOUT) ? rd_addr_q : wr_addr_q;

    sample_ram #(
        .MAX_DATA (MAX_DATA),
        .DWIDTH   (DWIDTH),
        .AWIDTH   (AWIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (we),
        .re_i    (re),
        .addr_i  (ram_addr),
        .wdata_i (bus.din),
        .rdata_o (ram_rdata)
    );

    // The RAM read register is the dout register; it only loads when the
    // output slot is free, so it holds steady under backpressure. Gating with
    // the reset-cleared valid flag gives dout=0 without resetting the RAM.
    assign bus.dout       = dout_valid_q ? ram_rdata : '0;
    assign bus.dout_valid = dout_valid_q;
    assign busy           = (state_q == ARMED) || (state_q == CAPTURE) || (state_q == READOUT);
    assign done           = (state_q == DONE);
    assign wr_addr        = wr_addr_q;

`ifdef CAPTURE_CTRL_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (bus.din_valid && !we && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_capture_ctrl.sv
module tb_capture_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, trig, abort, rd_start;
    logic        busy, done;
    logic [2:0]  wr_addr;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    capture_ctrl_if #(.DWIDTH(8)) bus ();

    capture_ctrl #(
        .MAX_DATA (8),
        .DWIDTH   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .trig     (trig),
        .abort    (abort),
        .rd_start (rd_start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .wr_addr  (wr_addr),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Arm, trigger and capture 8 words; din_valid strobes one cycle in 'gap'.
    task automatic run_capture(input int gap, input logic [7:0] base);
        int k = 0;
        int cyc = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("armed_busy", 32'(busy), 1);
        trig = 1'b1;
        while (k < 8 && cyc < 200) begin
            if (cyc % gap == 0) begin
                bus.din_valid = 1'b1;
                bus.din       = base + 8'(k);
                exp_q.push_back(base + 8'(k));
                k++;
            end else begin
                bus.din_valid = 1'b0;
                bus.din       = 8'hEE;
            end
            @(negedge clk);
            cyc++;
            check("wr_addr", 32'(wr_addr), 32'(k % 8));
        end
        bus.din_valid = 1'b0;
        trig          = 1'b0;
        check("cap_done", 32'(done), 1);
        check("cap_busy", 32'(busy), 0);
    endtask

    // Read everything back, popping the scoreboard on each transfer.
    task automatic run_readout(input bit toggle);
        int cyc = 0;
        int first = -1;
        int last = -1;
        logic [7:0] held = '0;
        bit stalled = 1'b0;
        logic [7:0] e;
        rd_start       = 1'b1;
        bus.dout_ready = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        while (exp_q.size() > 0 && cyc < 100) begin
            bus.dout_ready = toggle ? cyc[0] : 1'b1;
            if (stalled) begin
                check("stall_data", 32'(bus.dout), 32'(held));
                check("stall_valid", 32'(bus.dout_valid), 1);
            end
            stalled = 1'b0;
            if (bus.dout_valid && bus.dout_ready) begin
                e = exp_q.pop_front();
                check("rd_data", 32'(bus.dout), 32'(e));
                if (first < 0) first = cyc;
                last = cyc;
            end else if (bus.dout_valid) begin
                held    = bus.dout;
                stalled = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        check("rd_drained", 32'(exp_q.size()), 0);
        if (!toggle) begin
            check("rd_first_lat", 32'(first), 1);
            check("rd_span", 32'(last - first), 7);
        end
        check("rd_end_valid", 32'(bus.dout_valid), 0);
        check("rd_end_busy", 32'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_drop"}, 32'(drop_cnt), 0);
        check({tag, "_dvalid"}, 32'(bus.dout_valid), 0);
        check({tag, "_dout"}, 32'(bus.dout), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_drop;
        rst = 1'b1; start = 1'b0; trig = 1'b0; abort = 1'b0; rd_start = 1'b0;
        bus.din_valid = 1'b0; bus.din = '0; bus.dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back capture and full-throughput readout
        run_capture(1, 8'h10);
        run_readout(1'b0);

        // start ignored in DONE; readout under alternating backpressure
        run_capture(1, 8'h20);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_ign_start_done", 32'(done), 1);
        check("done_ign_start_busy", 32'(busy), 0);
        run_readout(1'b1);

        // Gapped strobes
        run_capture(3, 8'h30);
        run_readout(1'b0);

        // Abort at wr_addr=5, then a clean capture
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        trig  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.din_valid = 1'b1;
            bus.din       = 8'h40 + 8'(i);
            @(negedge clk);
        end
        check("abort_pre_addr", 32'(wr_addr), 5);
        bus.din_valid = 1'b0;
        trig  = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_addr", 32'(wr_addr), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        run_capture(1, 8'h60);
        run_readout(1'b0);

        // rd_start ignored in IDLE
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        check("idle_rd_busy", 32'(busy), 0);
        check("idle_rd_valid", 32'(bus.dout_valid), 0);
        @(negedge clk);
        check("idle_rd_valid2", 32'(bus.dout_valid), 0);

        // Reset in the middle of a readout
        run_capture(1, 8'h50);
        rd_start       = 1'b1;
        bus.dout_ready = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrd_valid", 32'(bus.dout_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrd_rst");
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);

        // Drops while IDLE
        bus.din_valid = 1'b1;
        repeat (20) @(negedge clk);
        bus.din_valid = 1'b0;
        @(negedge clk);
`ifdef CAPTURE_CTRL_DROP_CNT_EN
        exp_drop = 16'd20;
`else
        exp_drop = 16'd0;
`endif
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        check("drop_idle_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter MAX_DATA, default 256: number of sample words in the capture buffer (power of 2 not required, >=2).
REQ-002 Parameter DWIDTH, default 8: sample width in bits.
REQ-003 Localparam AWIDTH = $clog2(MAX_DATA): buffer address width.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  pulse; arms the capture when IDLE.
REQ-007 trig  in  1  level; begins capture when ARMED.
REQ-008 abort  in  1  pulse; returns to IDLE from any state.
REQ-009 din_valid  in  1  input sample strobe.
REQ-010 din  in  DWIDTH  input sample.
REQ-011 rd_start  in  1  pulse; starts readout when DONE.
REQ-012 dout  out  DWIDTH  readout sample.
REQ-013 dout_valid  out  1  dout holds a valid sample.
REQ-014 dout_ready  in  1  downstream accepts dout.
REQ-015 busy  out  1  high in ARMED, CAPTURE, READOUT.
REQ-016 done  out  1  high in DONE only.
REQ-017 wr_addr  out  AWIDTH  current write address (buffer fill level).
REQ-018 drop_cnt  out  16  samples dropped while not capturing.

Function
REQ-019 States IDLE, ARMED, CAPTURE, DONE, READOUT; encoding from shared package.
REQ-020 IDLE -> ARMED on start; start ignored in all other states.
REQ-021 ARMED -> CAPTURE on cycle trig=1; a din_valid in that same cycle is written at address 0.
REQ-022 CAPTURE: each din_valid=1 cycle writes din at wr_addr, wr_addr+1; no write without din_valid.
REQ-023 Write at wr_addr == MAX_DATA-1 -> DONE next cycle, wr_addr wraps to 0; exactly MAX_DATA words stored.
REQ-024 DONE -> READOUT on rd_start; buffer contents retained in DONE indefinitely.
REQ-025 READOUT streams addresses 0..MAX_DATA-1 in order; first dout_valid no later than 2 cycles after rd_start.
REQ-026 dout and dout_valid registered; while dout_valid=1 and dout_ready=0, dout stable and dout_valid held.
REQ-027 Transfer = dout_valid & dout_ready; after a transfer, the next word may be valid the following cycle (full throughput, no bubbles with dout_ready held high).
REQ-028 After transfer of word MAX_DATA-1 -> IDLE, dout_valid=0 next cycle.
REQ-029 abort has priority over every other input: next state IDLE, dout_valid=0, wr_addr=0; buffer contents undefined.
REQ-030 din_valid while not in CAPTURE (or not ARMED-with-trig) counts as a drop; drop_cnt saturates at 16'hFFFF.
REQ-031 Buffer never written outside CAPTURE/trigger cycle; never read outside READOUT.

Reset
REQ-032 On rst: state IDLE, wr_addr=0, read pointer 0, dout=0, dout_valid=0, busy=0, done=0, drop_cnt=0.
REQ-033 rst mid-capture or mid-readout behaves as abort; buffer RAM contents not reset.

Configuration
REQ-034 Macro CAPTURE_CTRL_DROP_CNT_EN: defined -> drop counting per REQ-030; undefined -> drop_cnt tied to 0, no counter logic synthesized, port retained.

Structure
REQ-035 Package capture_pkg holds state enum and DROP_CNT_W=16 constant.
REQ-036 Buffer in sub-module sample_ram: single-port, synchronous write and registered read, MAX_DATA x DWIDTH, no reset.
REQ-037 Write and read address counters wrap at MAX_DATA-1, not at 2**AWIDTH.

Verification (MAX_DATA=8, DWIDTH=8)
REQ-038 start, trig, din_valid every cycle with din=0x10..0x17 -> done=1 after 8th write, wr_addr=0; rd_start with dout_ready=1 -> dout 0x10..0x17 on 8 consecutive cycles, then IDLE.
REQ-039 Readout with dout_ready toggling 1/0 -> each word transferred once, dout stable while stalled, order preserved.
REQ-040 din_valid gapped (1 of 3 cycles) during CAPTURE -> only strobed samples stored, wr_addr increments only on strobes.
REQ-041 abort at wr_addr=5 -> IDLE next cycle, wr_addr=0, busy=0; new start/trig capture completes normally.
REQ-042 din_valid=1 for 20 cycles in IDLE -> drop_cnt=20 with CAPTURE_CTRL_DROP_CNT_EN, 0 without.
REQ-043 rst asserted mid-READOUT -> all outputs at reset values next cycle; start ignored in DONE, rd_start ignored in IDLE.
